// File: rtl/fifo_rd_ptr_ctrl.sv
// fifo_rd_ptr_ctrl: async FIFO read-domain pointer, empty/almost-empty flags and fill level.
// Define FIFO_RD_UNDERFLOW_EN to add the sticky rd_underflow flag with its rd_uf_clr clear.
module fifo_rd_ptr_ctrl #(
    parameter int ADDR_W        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wr_ptr_gray,
`ifdef FIFO_RD_UNDERFLOW_EN
    input  logic              rd_uf_clr,
    output logic              rd_underflow,
`endif
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_empty,
    output logic              rd_aempty,
    output logic [ADDR_W:0]   rd_level
);
    localparam logic [ADDR_W:0] AE = AEMPTY_THRESH[ADDR_W:0];

    logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q;
    logic [ADDR_W:0] rbin, rbin_next, gnext, wq_gray, wq_bin, lvl_next;
    logic rd_acc;

    assign rd_acc    = rd_en & ~rd_empty;
    assign rbin_next = rbin + (ADDR_W+1)'(rd_acc);
    assign gnext     = rbin_next ^ (rbin_next >> 1);
    assign wq_gray   = sync_q[SYNC_STAGES-1];
    assign lvl_next  = wq_bin - rbin_next;
    assign rd_addr   = rbin[ADDR_W-1:0];

    // Each binary bit is the XOR of all Gray bits at or above it
    genvar g;
    generate
        for (g = 0; g <= ADDR_W; g++) begin : g2b
            assign wq_bin[g] = ^(wq_gray >> g);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            rbin        <= '0;
            rd_ptr_gray <= '0;
            rd_empty    <= 1'b1;
            rd_aempty   <= 1'b1;
            rd_level    <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], wr_ptr_gray};
            rbin        <= rbin_next;
            rd_ptr_gray <= gnext;
            rd_empty    <= gnext == wq_gray;
            rd_aempty   <= lvl_next <= AE;
            rd_level    <= lvl_next;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_underflow <= 1'b0;
        else     rd_underflow <= (rd_en & rd_empty) | (rd_underflow & ~rd_uf_clr);
    end
`endif
endmodule
